// File: rtl/xbus_grant_arb.sv
// xbus_grant_arb: four-way round-robin bus arbiter with a dead turnaround
// cycle between owners and active-low one-hot grant strobes.
//
// Optional feature macro: XBUS_ARB_TIMEOUT_EN
//   defined   -> hold counter revokes a grant after MAX_HOLD+1 cycles,
//                pulses timeout and locks the offender out until it
//                drops its request.
//   undefined -> no counter / lockout; timeout is tied low.
//
// Ports:
//   clk       in   system clock, all state changes on rising edge
//   reset     in   asynchronous active-high reset
//   en        in   gate for new grants (existing grant unaffected)
//   req[3:0]  in   level requests, held high while owning
//   grant_n   out  active-low one-hot grant, all high when none
//   sel       out  binary index of current/last owner
//   busy      out  high while a grant is held
//   timeout   out  one-cycle pulse on forced release
module xbus_grant_arb #(
    parameter int CNT_W    = 8,
    parameter int MAX_HOLD = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] grant_n,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    // Reject an out-of-range hold limit at elaboration time.
    if (MAX_HOLD < 1 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_bad_hold
        $error("xbus_grant_arb: MAX_HOLD out of range for CNT_W");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] grant_n_q, grant_n_d;
    // sel_q doubles as the round-robin last-owner pointer: it is loaded
    // with the winner on every grant and holds through TURN/IDLE.
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;

    logic [3:0] elig;
    logic [1:0] win;
    logic [1:0] cand;
    logic       win_vld;

`ifdef XBUS_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       lock_q, lock_d;
    logic [3:0]       lock_set;
    logic             timeout_q, timeout_d;
    logic             hold_hit;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    assign hold_hit = (cnt_q == HOLD_LIM);
    assign elig     = req & ~lock_q;
`else
    assign elig     = req;
`endif

    // Search upward from last owner + 1; the last owner is visited
    // last (k = 4 wraps back onto sel_q), giving it lowest priority.
    always_comb begin
        win     = sel_q;
        win_vld = 1'b0;
        cand    = sel_q;
        for (int k = 1; k <= 4; k++) begin
            cand = sel_q + 2'(k);
            if (!win_vld && elig[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_n_d = grant_n_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
`ifdef XBUS_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        lock_set  = 4'b0000;
`endif
        unique case (state_q)
            IDLE: begin
                if (en && win_vld) begin
                    state_d   = GRANT;
                    grant_n_d = ~(4'b0001 << win);
                    sel_d     = win;
                    busy_d    = 1'b1;
`ifdef XBUS_ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            GRANT: begin
                // A normal release wins over a hold limit hit on
                // the same edge.
                if (!req[sel_q]) begin
                    state_d   = TURN;
                    grant_n_d = 4'b1111;
                    busy_d    = 1'b0;
                end
`ifdef XBUS_ARB_TIMEOUT_EN
                else if (hold_hit) begin
                    state_d         = TURN;
                    grant_n_d       = 4'b1111;
                    busy_d          = 1'b0;
                    timeout_d       = 1'b1;
                    lock_set[sel_q] = 1'b1;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                grant_n_d = 4'b1111;
                busy_d    = 1'b0;
            end
        endcase
    end

`ifdef XBUS_ARB_TIMEOUT_EN
    // A lock is released once its requester is seen idle; a fresh
    // revoke on the same edge still sets it (its req is high then).
    assign lock_d = (lock_q & req) | lock_set;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_n_q <= 4'b1111;
            sel_q     <= 2'd3;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_n_q <= grant_n_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
        end
    end

`ifdef XBUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            lock_q    <= 4'b0000;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            lock_q    <= lock_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign grant_n = grant_n_q;
    assign sel     = sel_q;
    assign busy    = busy_q;

endmodule
